// File: rtl/rv32m_muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// rv32m_muldiv_unit_if
// Request/result bundle between the issue stage, the RV32M multiply/divide
// unit and the writeback mux.
//   in_valid  / in_ready   : operation request handshake
//   funct3                 : RV32M operation select
//   rs1_data / rs2_data    : source operands from the register file
//   rd_addr                : destination index carried with the operation
//   out_valid / out_ready  : result handshake towards writeback
//   out_rd / out_data      : destination index and 32-bit result
// master = requester/consumer side, slave = the execution unit.
// ---------------------------------------------------------------------------
interface rv32m_muldiv_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_addr;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_data;

  modport master (
    output in_valid, funct3, rs1_data, rs2_data, rd_addr, out_ready,
    input  in_ready, out_valid, out_rd, out_data
  );

  modport slave (
    input  in_valid, funct3, rs1_data, rs2_data, rd_addr, out_ready,
    output in_ready, out_valid, out_rd, out_data
  );
endinterface

// File: rtl/rv32m_muldiv_unit.sv
// ---------------------------------------------------------------------------
// rv32m_muldiv_unit
// Iterative RV32M multiply/divide unit, one operation in flight.
// Normal operations iterate 32 cycles (radix-2 shift-add multiply or
// restoring divide) followed by a sign-fix/result-select cycle; divide by
// zero and signed overflow skip the iterations.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   flush  : synchronous kill of any in-flight or pending result
//   bus    : request/result handshake (see rv32m_muldiv_unit_if)
// ---------------------------------------------------------------------------
module rv32m_muldiv_unit (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  rv32m_muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] b_q, b_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic        negRes_q, negRes_d;
  logic        negRem_q, negRem_d;
  logic [31:0] outData_q, outData_d;
  logic [4:0]  outRd_q, outRd_d;

  // Operand signedness and magnitudes, decoded straight from the request.
  // MULH/DIV/REM treat both operands as signed, MULHSU only rs1.
  logic        aSigned, bSigned, aNeg, bNeg;
  logic [31:0] magA, magB;
  logic        divZero, divOvf;
  logic [31:0] specRes;

  assign aSigned = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                   (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
  assign bSigned = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                   (bus.funct3 == 3'b110);
  assign aNeg    = aSigned && bus.rs1_data[31];
  assign bNeg    = bSigned && bus.rs2_data[31];
  assign magA    = aNeg ? (32'd0 - bus.rs1_data) : bus.rs1_data;
  assign magB    = bNeg ? (32'd0 - bus.rs2_data) : bus.rs2_data;

  // Special cases finish without iterating. funct3[1] distinguishes the
  // remainder ops; funct3[0]==0 picks the signed DIV/REM pair for overflow.
  assign divZero = bus.funct3[2] && (bus.rs2_data == 32'd0);
  assign divOvf  = bus.funct3[2] && !bus.funct3[0] &&
                   (bus.rs1_data == 32'h8000_0000) &&
                   (bus.rs2_data == 32'hFFFF_FFFF);
  assign specRes = divZero ? (bus.funct3[1] ? bus.rs1_data : 32'hFFFF_FFFF)
                           : (bus.funct3[1] ? 32'd0 : 32'h8000_0000);

  // One iteration of each datapath. The multiplier sits in the low half of
  // the product and is shifted out as the partial sum is shifted in; the
  // dividend shifts out of the quotient register into the partial remainder.
  logic [32:0] mulSum;
  logic [63:0] mulNext;
  logic [32:0] remShift, remDiff;

  assign mulSum   = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, b_q} : 33'd0);
  assign mulNext  = {mulSum, prod_q[31:1]};
  assign remShift = {rem_q, quot_q[31]};
  assign remDiff  = remShift - {1'b0, b_q};

  // Sign correction and result selection used in the FIX cycle.
  logic [63:0] prodFix;
  logic [31:0] quotFix, remFix, fixResult;

  assign prodFix = negRes_q ? (64'd0 - prod_q) : prod_q;
  assign quotFix = negRes_q ? (32'd0 - quot_q) : quot_q;
  assign remFix  = negRem_q ? (32'd0 - rem_q) : rem_q;

  always_comb begin
    fixResult = remFix;
    case (op_q)
      3'b000:                 fixResult = prodFix[31:0];
      3'b001, 3'b010, 3'b011: fixResult = prodFix[63:32];
      3'b100, 3'b101:         fixResult = quotFix;
      default:                fixResult = remFix;
    endcase
  end

  // Next-state logic. flush wins over everything and leaves the output
  // registers untouched. Special cases preload their answer into both the
  // quotient and remainder registers with the sign flags cleared, so the
  // ordinary FIX selection delivers it one cycle after accept.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    b_d       = b_q;
    prod_d    = prod_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    negRes_d  = negRes_q;
    negRem_d  = negRem_q;
    outData_d = outData_q;
    outRd_d   = outRd_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            op_d     = bus.funct3;
            rd_d     = bus.rd_addr;
            cnt_d    = 6'd0;
            b_d      = magB;
            prod_d   = {32'd0, magA};
            quot_d   = magA;
            rem_d    = 32'd0;
            negRes_d = aNeg ^ bNeg;
            negRem_d = aNeg;
            if (divZero || divOvf) begin
              quot_d   = specRes;
              rem_d    = specRes;
              negRes_d = 1'b0;
              negRem_d = 1'b0;
              state_d  = FIX;
            end else begin
              state_d  = CALC;
            end
          end
        end
        CALC: begin
          prod_d = mulNext;
          if (!remDiff[32]) begin
            rem_d  = remDiff[31:0];
            quot_d = {quot_q[30:0], 1'b1};
          end else begin
            rem_d  = remShift[31:0];
            quot_d = {quot_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_d = FIX;
        end
        FIX: begin
          outData_d = fixResult;
          outRd_d   = rd_q;
          state_d   = DONE;
        end
        DONE: begin
          if (bus.out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers; reset returns the unit to an idle,
  // cleared result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      op_q      <= 3'd0;
      rd_q      <= 5'd0;
      b_q       <= 32'd0;
      prod_q    <= 64'd0;
      quot_q    <= 32'd0;
      rem_q     <= 32'd0;
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
      outData_q <= 32'd0;
      outRd_q   <= 5'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      b_q       <= b_d;
      prod_q    <= prod_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      negRes_q  <= negRes_d;
      negRem_q  <= negRem_d;
      outData_q <= outData_d;
      outRd_q   <= outRd_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = outData_q;
  assign bus.out_rd    = outRd_q;

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_rv32m_muldiv_unit
// Directed bench for rv32m_muldiv_unit. The stimulus process issues
// operations and pushes the hand-computed {rd, data} into a queue; the
// monitor pops and compares on every result handshake.
// ---------------------------------------------------------------------------
module tb_rv32m_muldiv_unit;

  logic clk;
  logic rst_n;
  logic flush;

  rv32m_muldiv_unit_if bus();

  rv32m_muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  int nChecks = 0;
  int nFails  = 0;

  logic [36:0] expQ[$];
  logic [36:0] expItem;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so a stuck DUT still ends the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point shared by the stimulus and monitor processes.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: inputs change just after rising edges, so the falling edge sees
  // the values the next rising edge will act on.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL unexpected result: got rd=%0d data=0x%0h, expected none",
                 bus.out_rd, bus.out_data);
      end else begin
        expItem = expQ.pop_front();
        checkOutput("result rd", 64'(bus.out_rd), 64'(expItem[36:32]));
        checkOutput("result data", 64'(bus.out_data), 64'(expItem[31:0]));
      end
    end
  end

  // Issue one operation, check accept/latency/handoff timing, and optionally
  // hold out_ready low for holdCycles cycles once the result is up.
  task automatic applyStimulus(input string name, input logic [2:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic [31:0] expData,
                               input int expLat, input int holdCycles);
    int lat;
    int waitCnt;
    waitCnt = 0;
    while (!bus.in_ready && waitCnt < 100) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    checkOutput({name, " ready before issue"}, 64'(bus.in_ready), 64'd1);
    bus.out_ready = (holdCycles == 0);
    bus.in_valid  = 1'b1;
    bus.funct3    = op;
    bus.rs1_data  = a;
    bus.rs2_data  = b;
    bus.rd_addr   = rd;
    expQ.push_back({rd, expData});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.rs1_data = 32'hDEAD_BEEF;
    bus.rs2_data = 32'hCAFE_F00D;
    checkOutput({name, " busy after accept"}, 64'(bus.in_ready), 64'd0);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({name, " latency"}, 64'(lat), 64'(expLat));
    if (holdCycles > 0) begin
      for (int i = 0; i < holdCycles; i++) begin
        @(posedge clk); #1;
        checkOutput({name, " hold valid"}, 64'(bus.out_valid), 64'd1);
        checkOutput({name, " hold in_ready"}, 64'(bus.in_ready), 64'd0);
        checkOutput({name, " hold data"}, 64'(bus.out_data), 64'(expData));
        checkOutput({name, " hold rd"}, 64'(bus.out_rd), 64'(rd));
      end
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    checkOutput({name, " ready after handoff"}, 64'(bus.in_ready), 64'd1);
    checkOutput({name, " valid cleared"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    logic sawValid;
    rst_n         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.funct3    = 3'd0;
    bus.rs1_data  = 32'd0;
    bus.rs2_data  = 32'd0;
    bus.rd_addr   = 5'd0;
    bus.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #13;
    checkOutput("reset in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("reset out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset out_data", 64'(bus.out_data), 64'd0);
    checkOutput("reset out_rd", 64'(bus.out_rd), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] multiply group");
    applyStimulus("MUL 7*-3",      MUL,    32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33, 0);
    applyStimulus("MULH min*min",  MULH,   32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, 33, 0);
    applyStimulus("MULHSU -1*max", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFF, 33, 0);
    applyStimulus("MULHU max*max", MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 33, 0);

    $display("[TB] divide group");
    applyStimulus("DIV -7/2",      DIV,    32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD, 33, 0);
    applyStimulus("REM -7/2",      REM,    32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF, 33, 0);
    applyStimulus("DIVU 100/7",    DIVU,   32'd100,       32'd7,         5'd0,  32'd14,        33, 0);
    applyStimulus("REMU 100/7",    REMU,   32'd100,       32'd7,         5'd31, 32'd2,         33, 0);

    $display("[TB] special cases");
    applyStimulus("DIVU by zero",  DIVU,   32'h0000_1234, 32'd0,         5'd8,  32'hFFFF_FFFF, 1, 0);
    applyStimulus("REM by zero",   REM,    32'h0000_1234, 32'd0,         5'd9,  32'h0000_1234, 1, 0);
    applyStimulus("DIV overflow",  DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1, 0);
    applyStimulus("REM overflow",  REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0,         1, 0);

    $display("[TB] backpressure");
    applyStimulus("DIVU held",     DIVU,   32'd100,       32'd7,         5'd12, 32'd14,        33, 5);

    $display("[TB] flush during divide");
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.funct3    = DIV;
    bus.rs1_data  = 32'd1000;
    bus.rs2_data  = 32'd3;
    bus.rd_addr   = 5'd13;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    flush         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.funct3    = MUL;
    bus.rs1_data  = 32'd3;
    bus.rs2_data  = 32'd5;
    @(posedge clk); #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("flush idle", 64'(bus.in_ready), 64'd1);
    checkOutput("flush no valid", 64'(bus.out_valid), 64'd0);
    sawValid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      sawValid = sawValid | bus.out_valid;
    end
    checkOutput("flush no later valid", 64'(sawValid), 64'd0);
    checkOutput("flush keeps out_data", 64'(bus.out_data), 64'd14);

    $display("[TB] reset during calc");
    bus.in_valid = 1'b1;
    bus.funct3   = MUL;
    bus.rs1_data = 32'd3;
    bus.rs2_data = 32'd5;
    bus.rd_addr  = 5'd14;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("midreset out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("midreset out_data", 64'(bus.out_data), 64'd0);
    checkOutput("midreset out_rd", 64'(bus.out_rd), 64'd0);
    checkOutput("midreset in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sawValid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      sawValid = sawValid | bus.out_valid;
    end
    checkOutput("midreset no valid", 64'(sawValid), 64'd0);

    applyStimulus("MUL after reset", MUL, 32'd3, 32'd5, 5'd15, 32'd15, 33, 0);

    @(posedge clk); #1;
    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
